// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-control bus: instruction-memory port, redirect request and decode-side handshake.
interface ifu_fetch_ctrl_if;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;

    // Fetch controller side
    modport master (
        output im_addr,
        input  im_instr,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output out_fault
    );

    // Memory / redirect source / decode side
    modport slave (
        input  im_addr,
        output im_instr,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  out_fault
    );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: sequential PC, 2-entry fetch buffer, redirect flush,
// halt on fetch-address fault. Optional performance counters behind IFU_PERF_CNT_EN.
module ifu_fetch_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    ifu_fetch_ctrl_if.master        bus
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]             perf_fetch,
    output logic [31:0]             perf_flush
`endif
);

    localparam int unsigned NUM_ENTRIES = 2;
    // One past the last valid byte address, kept 33 bits wide so it cannot wrap.
    localparam logic [32:0] LIMIT_ADDR  = 33'(BASE_ADDR) + (33'(DEPTH_WORDS) << 2);

    typedef enum logic {FETCH = 1'b0, HALT = 1'b1} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    entry_t      fifo_q [NUM_ENTRIES];
    entry_t      fifo_d [NUM_ENTRIES];
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    state_e      state_q, state_d;
    logic        fault_c;
    logic        pop_c;
    logic        push_c;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_flush_q, perf_flush_d;
`endif

    // Fetch-address fault: misaligned or outside instruction memory
    assign fault_c = (pc_q[1:0] != 2'b00)
                  || ({1'b0, pc_q} < {1'b0, BASE_ADDR})
                  || ({1'b0, pc_q} >= LIMIT_ADDR);

    // Buffer handshake; a redirect suppresses both sides in its cycle
    assign pop_c  = (count_q != 2'd0) && bus.out_ready && !bus.redirect_valid;
    assign push_c = (state_q == FETCH) && !bus.redirect_valid
                 && ((count_q < 2'd2) || pop_c);

    assign bus.im_addr   = pc_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_pc    = fifo_q[rd_ptr_q].pc;
    assign bus.out_instr = fifo_q[rd_ptr_q].instr;
    assign bus.out_fault = fifo_q[rd_ptr_q].fault;

    // Next-state: redirect flush, else push/pop on the buffer and PC advance
    always_comb begin
        fifo_d   = fifo_q;
        pc_d     = pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        state_d  = state_q;
`ifdef IFU_PERF_CNT_EN
        perf_fetch_d = perf_fetch_q;
        perf_flush_d = perf_flush_q;
`endif
        if (bus.redirect_valid) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            pc_d     = bus.redirect_pc;
            state_d  = FETCH;
`ifdef IFU_PERF_CNT_EN
            if (count_q != 2'd0) begin
                perf_flush_d = perf_flush_q + 32'd1;
            end
`endif
        end else begin
            if (push_c) begin
                fifo_d[wr_ptr_q].pc    = pc_q;
                fifo_d[wr_ptr_q].instr = fault_c ? 32'h0 : bus.im_instr;
                fifo_d[wr_ptr_q].fault = fault_c;
                wr_ptr_d = ~wr_ptr_q;
                pc_d     = pc_q + 32'd4;
                if (fault_c) begin
                    state_d = HALT;
                end
`ifdef IFU_PERF_CNT_EN
                perf_fetch_d = perf_fetch_q + 32'd1;
`endif
            end
            if (pop_c) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(push_c) - 2'(pop_c);
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                fifo_q[i] <= '0;
            end
            pc_q     <= BASE_ADDR;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            state_q  <= FETCH;
`ifdef IFU_PERF_CNT_EN
            perf_fetch_q <= 32'd0;
            perf_flush_q <= 32'd0;
`endif
        end else begin
            fifo_q   <= fifo_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
`ifdef IFU_PERF_CNT_EN
            perf_fetch_q <= perf_fetch_d;
            perf_flush_q <= perf_flush_d;
`endif
        end
    end

`ifdef IFU_PERF_CNT_EN
    assign perf_fetch = perf_fetch_q;
    assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Testbench for ifu_fetch_ctrl: queue-based reference model, negedge monitor scoreboard.
module tb_ifu_fetch_ctrl;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int unsigned DEPTH = 4096;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic clk;
    logic rst_n;
    ifu_fetch_ctrl_if bus ();
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_flush;
`endif

    ifu_fetch_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_flush (perf_flush)
`endif
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    // Reference model state: buffered entries, fetch PC, halted flag, counters
    exp_t        m_q[$];
    logic [31:0] m_pc;
    bit          m_halt;
    logic [31:0] m_fetch;
    logic [31:0] m_flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: an address-derived pattern
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign bus.im_instr = mem_word(bus.im_addr);

    function automatic bit is_fault(input logic [31:0] a);
        longint unsigned x;
        x = longint'(a);
        return (x % 4 != 0) || (x < longint'(BASE)) || (x >= longint'(BASE) + 4 * longint'(DEPTH));
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc    = BASE;
        m_halt  = 0;
        m_fetch = 0;
        m_flush = 0;
    endtask

    // One clock of the reference behaviour
    task automatic model_step(input bit rdy, input bit rd, input logic [31:0] rp);
        bit   popped;
        bit   f;
        exp_t e;
        if (rd) begin
            if (m_q.size() > 0) m_flush++;
            m_q.delete();
            m_pc   = rp;
            m_halt = 0;
        end else begin
            popped = (m_q.size() > 0) && rdy;
            if (popped) void'(m_q.pop_front());
            if (!m_halt && (m_q.size() < 2)) begin
                f       = is_fault(m_pc);
                e.pc    = m_pc;
                e.instr = f ? 32'h0 : mem_word(m_pc);
                e.fault = f;
                m_q.push_back(e);
                m_pc = m_pc + 32'd4;
                m_fetch++;
                if (f) m_halt = 1;
            end
        end
    endtask

    task automatic step(input bit rdy, input bit rd, input logic [31:0] rp);
        bus.out_ready      = rdy;
        bus.redirect_valid = rd;
        bus.redirect_pc    = rp;
        @(posedge clk);
        model_step(rdy, rd, rp);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges, checked before any edge
    task automatic async_reset();
        bus.redirect_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp("rst_out_valid", 32'(bus.out_valid), 32'h0);
        cmp("rst_im_addr", bus.im_addr, BASE);
        cmp("rst_out_pc", bus.out_pc, 32'h0);
        cmp("rst_out_instr", bus.out_instr, 32'h0);
        cmp("rst_out_fault", 32'(bus.out_fault), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare DUT state against the model's expected head entry
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
            cmp("im_addr", bus.im_addr, m_pc);
            if (m_q.size() != 0) begin
                cmp("out_pc", bus.out_pc, m_q[0].pc);
                cmp("out_instr", bus.out_instr, m_q[0].instr);
                cmp("out_fault", 32'(bus.out_fault), 32'(m_q[0].fault));
            end
`ifdef IFU_PERF_CNT_EN
            cmp("perf_fetch", perf_fetch, m_fetch);
            cmp("perf_flush", perf_flush, m_flush);
`endif
        end
    end

    initial begin
        logic [31:0] rp;
        int          sel;
        rst_n              = 1'b1;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        model_reset();
        @(negedge clk);
        async_reset();
        chk_en = 1;

        // Streaming from reset at full throughput
        for (int i = 0; i < 4; i++) step(1, 0, 0);

        // Back-pressure saturates the buffer, then drain without a gap
        async_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        cmp("sat_im_addr", bus.im_addr, 32'h0000_3008);
        cmp("sat_out_pc", bus.out_pc, 32'h0000_3000);
        for (int i = 0; i < 3; i++) step(1, 0, 0);

        // Redirect while full flushes the buffer
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 32'h0000_3100);
        cmp("flush_valid", 32'(bus.out_valid), 32'h0);
        step(1, 0, 0);
        cmp("redir_pc", bus.out_pc, 32'h0000_3100);
        for (int i = 0; i < 2; i++) step(1, 0, 0);

        // Misaligned redirect faults and halts until a good redirect
        step(1, 1, 32'h0000_3002);
        step(0, 0, 0);
        cmp("mis_fault", 32'(bus.out_fault), 32'h1);
        cmp("mis_instr", bus.out_instr, 32'h0);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        cmp("halt_empty", 32'(bus.out_valid), 32'h0);
        step(1, 1, 32'h0000_3000);
        for (int i = 0; i < 3; i++) step(1, 0, 0);

        // Last word of memory is good, the next one faults
        step(1, 1, 32'h0000_6FFC);
        step(0, 0, 0);
        step(0, 0, 0);
        cmp("end_ok_fault", 32'(bus.out_fault), 32'h0);
        step(1, 0, 0);
        cmp("end_pc", bus.out_pc, 32'h0000_7000);
        cmp("end_fault", 32'(bus.out_fault), 32'h1);
        for (int i = 0; i < 3; i++) step(1, 0, 0);

        // Reset while halted resumes fetching at the base address
        step(1, 1, 32'h0000_2FFC);
        step(1, 0, 0);
        async_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
            end else begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0: rp = BASE + ($urandom_range(0, DEPTH - 1) << 2);
                    1: rp = BASE + $urandom_range(0, 4 * DEPTH - 1);
                    2: rp = 32'h0000_6FF4;
                    3: rp = 32'h0000_2FF8;
                    4: rp = 32'hFFFF_FFFC;
                    default: rp = $urandom;
                endcase
                step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, rp);
            end
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

Interface
REQ-001 The block SHALL take parameter BASE_ADDR, default 32'h0000_3000, meaning the first valid instruction byte address and the reset PC.
REQ-002 The block SHALL take parameter DEPTH_WORDS, default 4096, meaning the number of 32-bit words in instruction memory.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port im_addr, output, 32 bits: byte address driven to the combinational instruction memory.
REQ-006 The block SHALL have port im_instr, input, 32 bits: instruction word returned combinationally for im_addr.
REQ-007 The block SHALL have port redirect_valid, input, 1 bit: branch/jump/exception redirect request.
REQ-008 The block SHALL have port redirect_pc, input, 32 bits: target byte address when redirect_valid=1.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the buffer head entry is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the decode stage accepts the head entry.
REQ-011 The block SHALL have ports out_pc, out_instr, and out_fault, outputs, 32/32/1 bits: the head entry's PC, instruction, and fetch-address fault flag.

Function
REQ-012 The block SHALL hold pc_q, a 2-entry FIFO of {pc, instr, fault}, a 2-bit count (0..2), and FSM state in {FETCH, HALT}.
REQ-013 im_addr SHALL equal pc_q combinationally.
REQ-014 fault SHALL be 1 if pc_q[1:0]!=0, pc_q<BASE_ADDR, or pc_q>=BASE_ADDR+4*DEPTH_WORDS; it SHALL be computed with 33-bit arithmetic so the limit does not wrap.
REQ-015 A pop SHALL occur when out_valid && out_ready && !redirect_valid.
REQ-016 A push SHALL occur when state==FETCH && !redirect_valid && (count<2 || pop).
REQ-017 On a push, the FIFO SHALL enqueue {pc_q, fault?32'h0:im_instr, fault}, and pc_q SHALL become pc_q+4 (mod 2^32).
REQ-018 A push whose fault=1 SHALL move state to HALT; in HALT, pushes SHALL stop and pc_q SHALL hold.
REQ-019 On redirect_valid=1, the block SHALL flush the FIFO (count<=0), set pc_q<=redirect_pc, and set state<=FETCH; in that same cycle push and pop SHALL both be suppressed.
REQ-020 out_valid SHALL equal (count!=0); out_pc, out_instr, and out_fault SHALL come from the head entry and hold stable while out_valid && !out_ready.
REQ-021 Latency SHALL be: the instruction at pc_q appears at out_* one cycle after the push edge; sustained throughput with out_ready=1 SHALL be 1 instruction/cycle.
REQ-022 When full (count=2) and pop, the block SHALL push and pop in the same cycle, leaving count=2; when count=0, pop SHALL be impossible.
REQ-023 The FIFO SHALL preserve order, using read/write pointers that wrap modulo 2.

Reset
REQ-024 While reset=0, the block SHALL asynchronously force pc_q=BASE_ADDR, count=0, pointers=0, state=FETCH, out_valid=0, and out_pc/out_instr/out_fault=0.
REQ-025 Reset asserted mid-operation SHALL discard all buffered entries and any pending HALT.
REQ-026 After reset is released, the first push SHALL occur at the first rising clk edge, fetching BASE_ADDR.

Configuration
REQ-027 With macro IFU_PERF_CNT_EN defined, the block SHALL add outputs perf_fetch (32 bits, incremented on each push) and perf_flush (32 bits, incremented on each redirect that discards count>0); both SHALL be reset to 0 and wrap at 2^32.
REQ-028 Without IFU_PERF_CNT_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Release reset with out_ready=1 and words 0x3000..0x300C preloaded -> out_valid=1 from cycle 1, out_pc 0x3000, 0x3004, 0x3008, 0x300C on consecutive cycles.
REQ-030 Hold out_ready=0 for 5 cycles after reset -> count saturates at 2, im_addr holds 0x3008, out_pc stays 0x3000; out_ready=1 -> 0x3000, 0x3004, 0x3008 in order with no gap.
REQ-031 Assert redirect_valid with redirect_pc=0x3100 while count=2 -> next cycle out_valid=0; following cycle out_pc=0x3100; perf_flush=1 (macro on).
REQ-032 Assert redirect_valid with redirect_pc=0x3002 -> entry out_pc=0x3002, out_fault=1, out_instr=0; state HALT, no further pushes until redirect 0x3000 resumes fetch.
REQ-033 Run sequentially from 0x6FFC -> entry 0x6FFC has fault=0, entry 0x7000 has fault=1, then HALT.
REQ-034 Drive reset=0 asynchronously between clock edges with count=2 -> out_valid=0 and im_addr=0x3000 immediately, without waiting for a clk edge.
